// File: rtl/branch_resolve.sv
// EX-side branch resolution: re-derives fetch's static prediction and
// issues redirects to IFU over a valid/ready handshake, with perf counters.
module branch_resolve #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [XLEN-1:0]  io_in_pc,
    input  logic [31:0]      io_in_inst,
    input  logic             io_in_taken,
    input  logic [XLEN-1:0]  io_in_jalr_target,
    input  logic [XLEN-1:0]  io_in_trap_target,
    output logic             io_redirect_valid,
    input  logic             io_redirect_ready,
    output logic [XLEN-1:0]  io_redirect_pc,
    output logic [1:0]       io_redirect_cause,
    output logic             io_flush,
    output logic [CNT_W-1:0] io_cnt_branch,
    output logic [CNT_W-1:0] io_cnt_mispred
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [1:0]        cause_q, cause_d;
    logic              flush_q;
    logic [CNT_W-1:0]  cnt_br_q, cnt_mp_q;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              is_br, is_jalr, is_trap;
    logic [XLEN-1:0]   b_off, br_tgt, pc4, pred_br, act_br;
    logic              mispred, need_rd, accept;

    assign opcode  = io_in_inst[6:0];
    assign funct3  = io_in_inst[14:12];
    assign is_br   = (opcode == 7'h63) && (funct3 != 3'd2) && (funct3 != 3'd3);
    assign is_jalr = (opcode == 7'h67) && (funct3 == 3'd0);
    assign is_trap = (io_in_inst == 32'h0000_0073) ||
                     (io_in_inst == 32'h0010_0073) ||
                     (io_in_inst == 32'h3020_0073);

    assign b_off = {{(XLEN-13){io_in_inst[31]}}, io_in_inst[31], io_in_inst[7],
                    io_in_inst[30:25], io_in_inst[11:8], 1'b0};

    assign pc4     = io_in_pc + XLEN'(4);
    assign br_tgt  = io_in_pc + b_off;
    assign pred_br = io_in_inst[31] ? br_tgt : pc4;
    assign act_br  = io_in_taken ? br_tgt : pc4;

    // JAL always resolves to its predicted target, so it never redirects
    assign mispred = is_br && (act_br != pred_br);
    assign need_rd = mispred || is_jalr || is_trap;

    assign io_in_ready = reset && (state_q == IDLE);
    assign accept      = io_in_valid && io_in_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        unique case (state_q)
            IDLE: begin
                if (accept && need_rd) begin
                    state_d = HOLD;
                    unique case (1'b1)
                        mispred: begin
                            pc_d    = act_br;
                            cause_d = 2'b01;
                        end
                        is_jalr: begin
                            pc_d    = {io_in_jalr_target[XLEN-1:1], 1'b0};
                            cause_d = 2'b10;
                        end
                        default: begin
                            pc_d    = io_in_trap_target;
                            cause_d = 2'b10;
                        end
                    endcase
                end
            end
            HOLD: begin
                if (io_redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            cause_q  <= 2'b00;
            flush_q  <= 1'b0;
            cnt_br_q <= '0;
            cnt_mp_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            flush_q <= accept && mispred;
            if (accept) begin
                cnt_br_q <= cnt_br_q + CNT_W'(is_br);
                cnt_mp_q <= cnt_mp_q + CNT_W'(mispred);
            end
        end
    end

    assign io_redirect_valid = (state_q == HOLD);
    assign io_redirect_pc    = pc_q;
    assign io_redirect_cause = (state_q == HOLD) ? cause_q : 2'b00;
    assign io_flush          = flush_q;
    assign io_cnt_branch     = cnt_br_q;
    assign io_cnt_mispred    = cnt_mp_q;

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-side counterpart of the fetch-stage static predictor. It takes each instruction leaving EX together with its resolved condition and targets, and recomputes the static prediction fetch made: JAL taken, conditional branch taken iff inst[31] set, JALR/ECALL/EBREAK/MRET fetch-stalled. It then determines whether fetch must be redirected. Redirects go to IFU over a valid/ready handshake, with a flush pulse on mispredicts and branch/mispredict performance counters.

## Interface
- XLEN, 64, PC/target width
- CNT_W, 32, performance counter width
- clock  in  1  clock
- reset  in  1  synchronous, active-low reset
- io_in_valid  in  1  EX instruction valid
- io_in_ready  out  1  unit can accept an instruction
- io_in_pc  in  XLEN  PC of the instruction
- io_in_inst  in  32  raw instruction
- io_in_taken  in  1  resolved branch condition (meaningful for conditional branches only)
- io_in_jalr_target  in  XLEN  rs1+imm from EX
- io_in_trap_target  in  XLEN  mtvec (ECALL/EBREAK) or mepc (MRET)
- io_redirect_valid  out  1  redirect request to IFU
- io_redirect_ready  in  1  IFU accepts redirect
- io_redirect_pc  out  XLEN  new fetch PC
- io_redirect_cause  out  2  01 = branch mispredict, 10 = stall release (jump class), 00 when idle
- io_flush  out  1  one-cycle pulse: kill younger instructions in ID/EX
- io_cnt_branch  out  CNT_W  conditional branches resolved
- io_cnt_mispred  out  CNT_W  mispredicted conditional branches

## Operation
- Classification on io_in_inst:
  - JAL: opcode 0x6F
  - BR: opcode 0x63 with funct3 in {0,1,4,5,6,7}
  - JALR: opcode 0x67 with funct3 0
  - TRAP: inst == 0x00000073, 0x00100073 or 0x30200073
  - Everything else: OTHER
- Offsets:
  - b_off = sext({inst[31],inst[7],inst[30:25],inst[11:8],0})
  - j_off = sext({inst[31],inst[19:12],inst[20],inst[30:21],0})
  - Both sign-extended to XLEN; all adds are modulo 2^XLEN.
- Predicted next PC:
  - JAL: pc+j_off
  - BR: pc+b_off if inst[31], else pc+4
- Actual next PC:
  - BR: taken ? pc+b_off : pc+4
  - JAL: pc+j_off
  - JALR: jalr_target with bit0 cleared
  - TRAP: trap_target
- Redirect rules:
  - Mispredict (cause 01): BR with actual != predicted.
  - Release (cause 10): every JALR or TRAP, unconditionally.
  - JAL and OTHER never redirect.
- FSM, 2 states:
  - IDLE: io_in_ready=1. On io_in_valid & ready (accept):
    - if a redirect is needed, latch target and cause, go to HOLD;
    - else stay in IDLE.
  - HOLD: io_in_ready=0; io_redirect_valid=1; pc and cause are held stable. On io_redirect_valid & io_redirect_ready, go to IDLE.
- io_flush: registered; high only in the first HOLD cycle, and only when cause=01.
- Counters, updated on accept and wrapping at 2^CNT_W:
  - io_cnt_branch += 1 for each BR.
  - io_cnt_mispred += 1 for each mispredicted BR.

## Timing
- Reset (reset==0 at a clock edge):
  - state IDLE, io_redirect_valid=0, io_redirect_pc=0, io_redirect_cause=00, io_flush=0, both counters 0.
  - io_in_ready reads 0 while reset is low; inputs are ignored.
- Reset asserted in HOLD drops a pending redirect with no handshake.
- Accept at edge N gives io_redirect_valid=1 (and io_flush if cause 01) in cycle N+1.
- Redirect taken at edge M gives IDLE and io_in_ready=1 in cycle M+1. The minimum turnaround from one redirecting instruction to the next accept is 2 cycles.
- Backpressure: while io_redirect_ready=0, the FSM stays in HOLD and pc/cause are stable; io_flush is not re-pulsed.
- Back-to-back non-redirecting instructions are accepted every cycle.
- Counters change in the cycle after accept and are visible combinationally from their registers.

## Test plan
- pc=0x80000010, inst=0xFE000CE3 (beq x0,x0,-8), taken=1 -> no redirect; cnt_branch=1; cnt_mispred=0.
- Same pc and inst, taken=0 -> next cycle: redirect_valid=1, pc=0x80000014, cause=01, flush=1 for one cycle; cnt_mispred=1.
- pc=0x80000000, inst=0x00000863 (beq +16), taken=1 -> redirect pc=0x80000010, cause=01. Same with taken=0 -> no redirect.
- inst=0x30200073 (mret), trap_target=0x80001234 -> redirect pc=0x80001234, cause=10, flush=0; counters unchanged.
- JALR with jalr_target=0x80000101, redirect_ready held 0 for 3 cycles:
  - redirect_valid stays 1 and pc stays 0x80000100 throughout;
  - io_in_ready=0 throughout;
  - the cycle after ready=1, io_in_ready=1.
- reset low during HOLD -> next cycle: redirect_valid=0, cause=00, counters=0, state IDLE.
